// File: rtl/fifo_read_packer.sv
// fifo_read_packer: pops DSIZE-bit entries from the read side of a dual-clock
// FIFO and packs LANES of them into one wide word on a valid/ready master port.
// Lane 0 (first popped) lands in the least significant bits.
// Optional feature: define PACK_TIMEOUT_EN to flush a partially filled word
// after TO_CYCLES idle cycles; m_keep then marks which lanes hold data.
// Handshake: a word transfers at a rising edge where m_valid && m_ready; once
// m_valid is high, m_data/m_keep hold stable until that edge.
// Reset: rrst_n is synchronous and active-high despite its name.
module fifo_read_packer #(
   parameter int DSIZE     = 8,
   parameter int LANES     = 4,
   parameter int TO_CYCLES = 16
) (
   input  logic                   rclk,
   input  logic                   rrst_n,
   input  logic                   rempty,
   input  logic [DSIZE-1:0]       rdata,
   output logic                   r_valid,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DSIZE*LANES-1:0] m_data,
   output logic [LANES-1:0]       m_keep,
   output logic                   dbg_state_o
);

   localparam int CW = $clog2(LANES + 1);
   localparam int W  = DSIZE * LANES;

   typedef enum logic {S_FILL = 1'b0, S_OUT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    icnt_q, icnt_d;   // pops issued for the current word
   logic [CW-1:0]    ccnt_q, ccnt_d;   // beats captured; also the next lane index
   logic             cap_q;            // a pop last cycle -> rdata is valid now
   logic [W-1:0]     lane_q, lane_d;   // lanes assembled so far, unused lanes zero
   logic [W-1:0]     m_data_q, m_data_d;
   logic [LANES-1:0] m_keep_q, m_keep_d;
   logic             pop;

`ifdef PACK_TIMEOUT_EN
   localparam int IW = $clog2(TO_CYCLES + 1);
   logic [IW-1:0]    idle_q, idle_d;
`else
   logic [31:0]      to_cycles_unused;
   assign to_cycles_unused = 32'(TO_CYCLES);
`endif

   // Pop request: only while filling, never while in reset, at most LANES per word.
   assign pop         = !rrst_n && (state_q == S_FILL) && !rempty && (icnt_q < CW'(LANES));
   assign r_valid     = pop;
   assign m_valid     = (state_q == S_OUT);
   assign m_data      = m_data_q;
   assign m_keep      = m_keep_q;
   assign dbg_state_o = state_q;

   // Next-state: lane capture, word completion, optional idle flush, output handshake.
   always_comb begin
      state_d  = state_q;
      icnt_d   = icnt_q;
      ccnt_d   = ccnt_q;
      lane_d   = lane_q;
      m_data_d = m_data_q;
      m_keep_d = m_keep_q;
`ifdef PACK_TIMEOUT_EN
      idle_d   = '0;
`endif
      if (pop) icnt_d = icnt_q + CW'(1);
      case (state_q)
         S_FILL: begin
            if (cap_q) begin
               for (int k = 0; k < LANES; k++) begin
                  if (ccnt_q == CW'(k)) lane_d[k*DSIZE +: DSIZE] = rdata;
               end
               ccnt_d = ccnt_q + CW'(1);
               if (ccnt_q == CW'(LANES - 1)) begin
                  m_data_d = lane_d;
                  m_keep_d = '1;
                  state_d  = S_OUT;
               end
            end
`ifdef PACK_TIMEOUT_EN
            // Idle means a partial word with nothing in flight and no new pop.
            else if ((ccnt_q != '0) && (icnt_q == ccnt_q) && !pop) begin
               idle_d = idle_q + IW'(1);
               if (idle_d == IW'(TO_CYCLES)) begin
                  m_data_d = lane_q;
                  for (int k = 0; k < LANES; k++) m_keep_d[k] = (CW'(k) < ccnt_q);
                  state_d  = S_OUT;
                  idle_d   = '0;
               end
            end
`endif
         end
         S_OUT: begin
            if (m_ready) begin
               state_d = S_FILL;
               icnt_d  = '0;
               ccnt_d  = '0;
               lane_d  = '0;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   // State register with synchronous active-high reset; reset drops any partial word.
   always_ff @(posedge rclk) begin
      if (rrst_n) begin
         state_q  <= S_FILL;
         icnt_q   <= '0;
         ccnt_q   <= '0;
         cap_q    <= 1'b0;
         lane_q   <= '0;
         m_data_q <= '0;
         m_keep_q <= '0;
`ifdef PACK_TIMEOUT_EN
         idle_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         icnt_q   <= icnt_d;
         ccnt_q   <= ccnt_d;
         cap_q    <= pop;
         lane_q   <= lane_d;
         m_data_q <= m_data_d;
         m_keep_q <= m_keep_d;
`ifdef PACK_TIMEOUT_EN
         idle_q   <= idle_d;
`endif
      end
   end

endmodule
